// File: rtl/state_dump_unit.sv
// Post-run state reader: streams register file, then data memory, over valid/ready.
// Optional trailing checksum word when DUMP_CHECKSUM_EN is defined.
module state_dump_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 3,
  parameter int MEM_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [REG_AW-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic [MEM_AW-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_tag,
  output logic [MEM_AW-1:0] out_index,
  output logic              out_last
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REG,
    S_MEM,
`ifdef DUMP_CHECKSUM_EN
    S_CSUM,
`endif
    S_FIN
  } state_t;

  localparam logic [1:0] TAG_REG = 2'b00;
  localparam logic [1:0] TAG_MEM = 2'b01;
`ifdef DUMP_CHECKSUM_EN
  localparam logic [1:0] TAG_CSUM = 2'b10;
`endif

  localparam logic [MEM_AW-1:0] REG_LAST =
    MEM_AW'((1 << REG_AW) - 1);
  localparam logic [MEM_AW-1:0] MEM_LAST = '1;

  state_t            state_q, state_d;
  logic [MEM_AW-1:0] ptr_q, ptr_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        tag_q, tag_d;
  logic [MEM_AW-1:0] index_q, index_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  logic load;
  logic accept;

  assign load   = !valid_q || out_ready;
  assign accept = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    index_d = index_q;
    last_d  = last_q;
    done_d  = 1'b0;
`ifdef DUMP_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    // A drained word clears valid unless a new one loads below.
    if (accept) valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_REG;
          ptr_d   = '0;
`ifdef DUMP_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      S_REG: begin
        if (load) begin
          valid_d = 1'b1;
          data_d  = rf_data;
          tag_d   = TAG_REG;
          index_d = ptr_q;
          last_d  = 1'b0;
`ifdef DUMP_CHECKSUM_EN
          sum_d   = sum_q + rf_data;
`endif
          if (ptr_q == REG_LAST) begin
            state_d = S_MEM;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + MEM_AW'(1);
          end
        end
      end
      S_MEM: begin
        if (load) begin
          valid_d = 1'b1;
          data_d  = dm_data;
          tag_d   = TAG_MEM;
          index_d = ptr_q;
`ifdef DUMP_CHECKSUM_EN
          last_d  = 1'b0;
          sum_d   = sum_q + dm_data;
`else
          last_d  = (ptr_q == MEM_LAST);
`endif
          if (ptr_q == MEM_LAST) begin
            ptr_d = '0;
`ifdef DUMP_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_FIN;
`endif
          end else begin
            ptr_d = ptr_q + MEM_AW'(1);
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      S_CSUM: begin
        if (load) begin
          valid_d = 1'b1;
          data_d  = sum_q;
          tag_d   = TAG_CSUM;
          index_d = '0;
          last_d  = 1'b1;
          state_d = S_FIN;
        end
      end
`endif
      S_FIN: begin
        if (accept) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      index_q <= index_d;
      last_q  <= last_d;
      done_q  <= done_d;
`ifdef DUMP_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign rf_addr   = (state_q == S_REG) ? ptr_q[REG_AW-1:0] : '0;
  assign dm_addr   = (state_q == S_MEM) ? ptr_q : '0;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_tag   = tag_q;
  assign out_index = index_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_state_dump_unit.sv
// Directed bench for state_dump_unit: full streams, stalls, reset, start filtering.
// Follows DUMP_CHECKSUM_EN to expect the optional checksum word.
module tb_state_dump_unit;

  localparam int DATA_W = 32;
  localparam int REG_AW = 3;
  localparam int MEM_AW = 5;
  localparam int NR = 8;
  localparam int NM = 32;
`ifdef DUMP_CHECKSUM_EN
  localparam int NW = NR + NM + 1;
`else
  localparam int NW = NR + NM;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic [REG_AW-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic [MEM_AW-1:0] dm_addr;
  logic [DATA_W-1:0] dm_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_tag;
  logic [MEM_AW-1:0] out_index;
  logic              out_last;

  logic [DATA_W-1:0] rf [NR];
  logic [DATA_W-1:0] dm [NM];

  int vectors = 0;
  int miscompares = 0;

  assign rf_data = rf[rf_addr];
  assign dm_data = dm[dm_addr];

  always #5 clk = ~clk;

  state_dump_unit #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .MEM_AW(MEM_AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done),
    .rf_addr(rf_addr), .rf_data(rf_data),
    .dm_addr(dm_addr), .dm_data(dm_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag),
    .out_index(out_index), .out_last(out_last)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_sum();
    logic [DATA_W-1:0] s = '0;
    for (int i = 0; i < NR; i++) s = s + rf[i];
    for (int j = 0; j < NM; j++) s = s + dm[j];
    return s;
  endfunction

  task automatic chk_word(input int n);
    logic [DATA_W-1:0] d;
    logic [1:0]        t;
    logic [MEM_AW-1:0] x;
    logic              l;
    if (n < NR) begin
      d = rf[n]; t = 2'b00; x = MEM_AW'(n); l = 1'b0;
    end else if (n < NR + NM) begin
      d = dm[n-NR]; t = 2'b01; x = MEM_AW'(n - NR);
      l = (n == NR + NM - 1) && (NW == NR + NM);
    end else begin
      d = exp_sum(); t = 2'b10; x = '0; l = 1'b1;
    end
    chk($sformatf("data[%0d]", n), 64'(out_data), 64'(d));
    chk($sformatf("tag[%0d]", n), 64'(out_tag), 64'(t));
    chk($sformatf("index[%0d]", n), 64'(out_index), 64'(x));
    chk($sformatf("last[%0d]", n), 64'(out_last), 64'(l));
  endtask

  // mode 0: ready high; 1: ready 1,0,0,1,...; 2: ready low 100 cycles after first valid
  task automatic dump(input int mode, input int stop_at, input bit hold_start);
    int  n;
    bit  acc;
    start = 1'b1;
    step();
    if (!hold_start) start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("valid_after_start", 64'(out_valid), 64'd0);
    n = 0;
    for (int cyc = 0; cyc < 600 && n < stop_at; cyc++) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = (cyc >= 101);
      endcase
      acc = out_valid && out_ready;
      step();
      if (acc) n++;
      if (n < NW) begin
        chk("busy_in_dump", 64'(busy), 64'd1);
        chk("done_in_dump", 64'(done), 64'd0);
        if (mode != 1) chk("no_bubble", 64'(out_valid), 64'd1);
        if (out_valid) chk_word(n);
      end
    end
    chk("words_accepted", 64'(n), 64'(stop_at));
    if (stop_at == NW) begin
      chk("done_pulse", 64'(done), 64'd1);
      chk("busy_at_done", 64'(busy), 64'd0);
      chk("valid_at_done", 64'(out_valid), 64'd0);
      start = 1'b0;
      step();
      chk("done_clear", 64'(done), 64'd0);
      chk("busy_idle", 64'(busy), 64'd0);
      chk("valid_idle", 64'(out_valid), 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < NR; i++) rf[i] = DATA_W'(i + 1);
    for (int j = 0; j < NM; j++) dm[j] = DATA_W'(32'h100 + j);
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    chk("rst_index", 64'(out_index), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_rf_addr", 64'(rf_addr), 64'd0);
    chk("rst_dm_addr", 64'(dm_addr), 64'd0);

    // full stream at full rate, cycle exact
    dump(0, NW, 1'b0);

    // back-pressure pattern 1,0,0,1
    dump(1, NW, 1'b0);

    // reset after word 12 is accepted
    out_ready = 1'b1;
    dump(0, 13, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_data", 64'(out_data), 64'd0);
    chk("midrst_rf_addr", 64'(rf_addr), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst_no_done", 64'(done), 64'd0);
      chk("midrst_idle", 64'(busy), 64'd0);
    end
    dump(0, NW, 1'b0);

    // start held through the dump and the done edge is ignored
    dump(0, NW, 1'b1);

    // long stall on r0, then release
    dump(2, NW, 1'b0);

`ifdef DUMP_CHECKSUM_EN
    for (int i = 0; i < NR; i++) rf[i] = '0;
    for (int j = 0; j < NM; j++) dm[j] = 32'hFFFF_FFFF;
    chk("csum_model", 64'(exp_sum()), 64'hFFFF_FFE0);
    dump(0, NW, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/state_dump_unit.md
# state_dump_unit

Post-run state reader for the mini MIPS core. On a `start` pulse it walks the register file, then the data memory, through their read ports. It streams every word out over a valid/ready interface, so a host or bench can pull the final machine state back out of the design. It is the read-back counterpart of the preload path that fills instruction, register and data memories before a run. It sits beside the core and shares the register-file and data-memory read ports while the core is halted.

## Interface

Parameters:
- `DATA_W`, 32: word width of register file and data memory.
- `REG_AW`, 3: register-file address width; `2**REG_AW` registers dumped.
- `MEM_AW`, 5: data-memory word-address width; `2**MEM_AW` words dumped.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a dump; sampled only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse after the final word is accepted.
- `rf_addr`  out  REG_AW  register-file read address.
- `rf_data`  in  DATA_W  register-file read data, combinational on `rf_addr`.
- `dm_addr`  out  MEM_AW  data-memory word read address.
- `dm_data`  in  DATA_W  data-memory read data, combinational on `dm_addr`.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  consumer accepts the word on the edge where valid && ready.
- `out_data`  out  DATA_W  dumped word.
- `out_tag`  out  2  source: 00 register, 01 data memory, 10 checksum, 11 unused.
- `out_index`  out  MEM_AW  register or memory index of `out_data`; zero-extended for registers; 0 for checksum.
- `out_last`  out  1  marks the final word of the dump.

## Operation

- FSM states:
  - IDLE, REG, MEM, CSUM, FIN.
  - CSUM exists only with `DUMP_CHECKSUM_EN`.
- Transitions:
  - IDLE: on `start`, go to REG with the read pointer at 0.
  - REG: after register `2**REG_AW-1` is loaded into the output stage, go to MEM with the pointer at 0.
  - MEM: after memory word `2**MEM_AW-1` is loaded, go to CSUM if enabled, else FIN.
  - CSUM: after the checksum word is loaded, go to FIN.
  - FIN: wait until the last word is accepted, pulse `done`, return to IDLE.
- Output stage: a single register.
  - It loads a new word when `!out_valid || out_ready`, i.e. it is empty or draining.
  - While `out_valid && !out_ready`, `out_data`, `out_tag`, `out_index` and `out_last` hold stable.
- Read pointers:
  - `rf_addr` = pointer in REG, else 0.
  - `dm_addr` = pointer in MEM, else 0.
  - A pointer advances only on a load.
- Word count per dump: `2**REG_AW + 2**MEM_AW` words (40 at defaults), plus 1 if the checksum is enabled.
- `out_last`: set on the final memory word, or on the checksum word when enabled.
- `start` while busy is ignored.
- `out_ready` while `!out_valid` is ignored.
- Registers are dumped in full, including r0.

## Timing

- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_data`=0, `out_tag`=0, `out_index`=0, `out_last`=0, `rf_addr`=0, `dm_addr`=0; state IDLE.
- Latency:
  - `start` sampled at edge k: `busy`=1 after edge k.
  - First word (r0) is valid after edge k+1.
- Throughput: with `out_ready` held high, one word per cycle with no bubbles, including across the REG→MEM boundary.
- With `out_ready` held high at defaults, the last word is valid after edge k+40 and accepted at edge k+41. `done`=1 and `busy`=0 after edge k+41; `done` clears after edge k+42.
- Back-pressure: the stall length is unbounded; no word is dropped or duplicated.
- `rst` mid-dump: after the reset edge all outputs take their reset values and the state is IDLE. The partial stream is abandoned; there is no `done`.
- `start` on the same edge as `done` is ignored, because the state is FIN and not IDLE.

## Configuration

- Macro: `DUMP_CHECKSUM_EN`.
- Defined:
  - A running sum modulo 2^DATA_W accumulates each data word as it loads into the output stage.
  - The sum clears on `start` acceptance.
  - After the last memory word, one extra word is sent: `out_tag`=10, `out_index`=0, `out_data`=sum, `out_last`=1.
  - The dump is 41 words at defaults.
- Undefined:
  - No accumulator and no CSUM state.
  - `out_tag` is never 10.
  - `out_last` is on memory word `2**MEM_AW-1`.

## Test plan

- Registers preloaded with r_i = i+1 and memory with m_j = 0x100+j, `out_ready`=1, pulse `start` → 40 consecutive words: tags 00×8 then 01×32, data 1..8 then 0x100..0x11F, `out_last` only on index 31, `done` pulse one cycle after.
- Same preload, `out_ready` toggling 1,0,0,1,… → same 40-word sequence in order; fields stable during each stall.
- `rst` asserted after word 12 is accepted → next cycle `out_valid`=0, `busy`=0, no `done`; a subsequent `start` restarts from r0.
- `start` pulsed again during a dump and on the `done` edge → ignored; exactly one 40-word stream.
- With `DUMP_CHECKSUM_EN`, memory all 0xFFFFFFFF, registers all 0 → word 41 has tag 10, data = 32×0xFFFFFFFF mod 2^32 = 0xFFFFFFE0, and carries `out_last`.
- `out_ready`=0 held for 100 cycles after first valid → r0 held, `busy`=1; releasing gives a normal full stream.
